double_buffer_egress: RTL and testbench

//  Egress stage directly downstream of the double-buffered stall pipeline.
//  - Consumes the final stage's registered output (data + valid).
//  - Drives that stage's stall request, so no word is dropped.
//  - Buffers words in a D-entry FIFO.
//  - Re-presents words on a valid/accept interface to the consumer.
//

---
 rtl/double_buffer_egress_if.sv | 36 +++
 rtl/double_buffer_egress.sv | 91 +++++++++
 tb/tb_double_buffer_egress.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/double_buffer_egress_if.sv
// Egress handshake bundle: pipeline side (data/valid/stall) and
// consumer side (data/valid/accept) plus registered occupancy.
interface double_buffer_egress_if #(
    parameter int W = 32,
    parameter int D = 4
);
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  in_r;
    logic          in_vld_r;
    logic          stall_r;
    logic [W-1:0]  out_w;
    logic          out_vld;
    logic          out_accept;
    logic [CW-1:0] occupancy;

    modport master (
        output in_r,
        output in_vld_r,
        output out_accept,
        input  stall_r,
        input  out_w,
        input  out_vld,
        input  occupancy
    );

    modport slave (
        input  in_r,
        input  in_vld_r,
        input  out_accept,
        output stall_r,
        output out_w,
        output out_vld,
        output occupancy
    );
endinterface

// File: rtl/double_buffer_egress.sv
// D-entry FIFO egress behind the stall pipeline with a registered stall.
// Optional counters enabled by DOUBLE_BUFFER_EGRESS_STATS_EN.
module double_buffer_egress #(
    parameter int W = 32,
    parameter int D = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    double_buffer_egress_if.slave      bus
`ifdef DOUBLE_BUFFER_EGRESS_STATS_EN
    ,
    output logic [31:0]                stall_cycles_r,
    output logic [$clog2(D+1)-1:0]     hwm_r
`endif
);
    localparam int CW = $clog2(D + 1);
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push = bus.in_vld_r & ~stall_q;
    assign pop  = (count_q != '0) & bus.out_accept;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // Registered full flag: never combinational from out_accept
        stall_d  = (count_d == CW'(D));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_r;
        end
    end

    assign bus.out_w     = mem_q[rd_ptr_q];
    assign bus.out_vld   = (count_q != '0);
    assign bus.stall_r   = stall_q;
    assign bus.occupancy = count_q;

`ifdef DOUBLE_BUFFER_EGRESS_STATS_EN
    logic [31:0]   stall_cyc_q, stall_cyc_d;
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        if (bus.in_vld_r && stall_q && (stall_cyc_q != '1)) begin
            stall_cyc_d = stall_cyc_q + 32'd1;
        end
        hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cyc_q <= '0;
            hwm_q       <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            hwm_q       <= hwm_d;
        end
    end

    assign stall_cycles_r = stall_cyc_q;
    assign hwm_r          = hwm_q;
`endif
endmodule

// File: tb/tb_double_buffer_egress.sv
// Directed bench for double_buffer_egress (W=32, D=4).
module tb_double_buffer_egress;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    double_buffer_egress_if #(.W(W), .D(D)) bus ();

`ifdef DOUBLE_BUFFER_EGRESS_STATS_EN
    logic [31:0]   stall_cycles_r;
    logic [CW-1:0] hwm_r;
`endif

    double_buffer_egress #(.W(W), .D(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave)
`ifdef DOUBLE_BUFFER_EGRESS_STATS_EN
        ,
        .stall_cycles_r (stall_cycles_r),
        .hwm_r          (hwm_r)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic pushing;

        bus.in_r       = '0;
        bus.in_vld_r   = 1'b0;
        bus.out_accept = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_vld", bus.out_vld, 1'b0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_stall", bus.stall_r, 1'b0);

        bus.out_accept = 1'b1;
        step();
        check("empty_pop_ignored", bus.occupancy, 0);

        // 1) single word
        bus.in_r     = 32'hA5A5_0001;
        bus.in_vld_r = 1'b1;
        step();
        bus.in_vld_r = 1'b0;
        check("single_vld", bus.out_vld, 1'b1);
        check("single_data", bus.out_w, 32'hA5A5_0001);
        check("single_occ", bus.occupancy, 1);
        step();
        check("single_drain_vld", bus.out_vld, 1'b0);
        check("single_drain_occ", bus.occupancy, 0);

        // 2) fill
        bus.out_accept = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fill_nostall", bus.stall_r, 1'b0);
            bus.in_r     = 32'h10 + i;
            bus.in_vld_r = 1'b1;
            step();
        end
        check("full_stall", bus.stall_r, 1'b1);
        check("full_occ", bus.occupancy, 4);
        bus.in_r = 32'h14;
        step();
        step();
        check("held_occ", bus.occupancy, 4);
        check("held_stall", bus.stall_r, 1'b1);
        check("held_head", bus.out_w, 32'h10);

        // 3) one pop from full, held word enters
        bus.out_accept = 1'b1;
        step();
        bus.out_accept = 1'b0;
        check("pop_unstall", bus.stall_r, 1'b0);
        check("pop_occ", bus.occupancy, 3);
        check("pop_head", bus.out_w, 32'h11);
        step();
        bus.in_vld_r = 1'b0;
        check("refill_occ", bus.occupancy, 4);
        check("refill_stall", bus.stall_r, 1'b1);
        bus.out_accept = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("drain_order", bus.out_w, 32'h10 + i);
            step();
        end
        bus.out_accept = 1'b0;
        check("drain_empty", bus.out_vld, 1'b0);
        check("drain_stall", bus.stall_r, 1'b0);

        // 4) streaming with random accept
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 1000 && cyc < 20000) begin
            bus.in_vld_r   = (sent < 1000);
            bus.in_r       = 32'h1000 + sent;
            bus.out_accept = 1'($urandom_range(0, 1));
            pushing = bus.in_vld_r & ~bus.stall_r;
            if (bus.out_accept && bus.out_vld) begin
                check("stream_data", bus.out_w, 32'h1000 + rcvd);
                rcvd++;
            end
            if (pushing) sent++;
            step();
            cyc++;
            check("stream_occ_max", (bus.occupancy <= 4), 1'b1);
        end
        bus.in_vld_r   = 1'b0;
        bus.out_accept = 1'b0;
        check("stream_done", rcvd, 1000);
        check("stream_sent", sent, 1000);
        check("stream_empty", bus.out_vld, 1'b0);

        // 5) reset with three words held
        for (int i = 0; i < 3; i++) begin
            bus.in_r     = 32'h20 + i;
            bus.in_vld_r = 1'b1;
            step();
        end
        bus.in_vld_r = 1'b0;
        check("pre_rst_occ", bus.occupancy, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_vld", bus.out_vld, 1'b0);
        check("mid_rst_occ", bus.occupancy, 0);
        check("mid_rst_stall", bus.stall_r, 1'b0);
        bus.in_r     = 32'hBEEF;
        bus.in_vld_r = 1'b1;
        step();
        bus.in_vld_r = 1'b0;
        check("post_rst_vld", bus.out_vld, 1'b1);
        check("post_rst_data", bus.out_w, 32'hBEEF);
        check("post_rst_occ", bus.occupancy, 1);
        bus.out_accept = 1'b1;
        step();
        bus.out_accept = 1'b0;
        check("post_rst_drain", bus.occupancy, 0);

`ifdef DOUBLE_BUFFER_EGRESS_STATS_EN
        // 6) stall statistics
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stats_rst_cyc", stall_cycles_r, 0);
        check("stats_rst_hwm", hwm_r, 0);
        for (int i = 0; i < 4; i++) begin
            bus.in_r     = 32'h30 + i;
            bus.in_vld_r = 1'b1;
            step();
        end
        bus.in_r = 32'h34;
        for (int i = 0; i < 7; i++) step();
        bus.in_vld_r = 1'b0;
        check("stats_cycles", stall_cycles_r, 7);
        check("stats_hwm", hwm_r, 4);
        step();
        check("stats_idle", stall_cycles_r, 7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
